mem_stage_lsu: RTL

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It consumes the memory-side outputs of the EX/MEM pipeline register (address, store data, funct3, MemRead/MemWrite) and runs each access against a variable-latency data-memory port using a req/ack handshake. While an access is in flight it raises `stall_o`, which the hazard logic uses to deassert the `write` enable of the pipeline registers. It returns aligned, sign- or zero-extended load data, and flags misaligned, illegal or timed-out accesses.

---
 rtl/mem_stage_lsu.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu - load/store unit for the MEM stage of the RV32I pipeline.
//
// Runs one load or store per instruction against a variable-latency data
// memory port (req/ack). The pipeline is held through stall_o while the access
// is in flight. Load data comes back aligned and sign/zero-extended. Misaligned,
// illegal-funct3 and timed-out accesses are reported through err_o/err_cause_o.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_read_i        load request
//   mem_write_i       store request (wins when both are high)
//   funct3_i          access size / sign
//   addr_i            byte address
//   wdata_i           store data
//   stall_o           hold the pipeline (combinational)
//   rdata_o           extended load data (registered, held until next DONE)
//   rdata_valid_o     one-cycle pulse, load data valid
//   err_o             one-cycle pulse, access failed
//   err_cause_o       01 misaligned, 10 timeout, 11 illegal funct3, 00 ok
//   dmem_req_o        memory request
//   dmem_we_o         1 = write
//   dmem_addr_o       word-aligned address
//   dmem_be_o         byte enables
//   dmem_wdata_o      lane-replicated store data
//   dmem_ack_i        single-cycle completion
//   dmem_rdata_i      read word, valid with dmem_ack_i
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       funct3_r;
  logic [1:0]       offset_r;

  logic             access_s;
  logic             store_s;
  logic             illegal_s;
  logic             misaligned_s;
  logic             fail_s;
  logic             timeout_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;

  // Select the addressed byte/half from a read word and extend it.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'd0, b};
      3'b101:  extend_load = {16'd0, h};
      default: extend_load = word;
    endcase
  endfunction

  // Decode the presented access: legality, alignment, lanes and store data.
  always_comb begin
    access_s     = mem_read_i | mem_write_i;
    store_s      = mem_write_i;
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    be_s         = 4'b1111;
    wdata_s      = wdata_i;

    case (funct3_i)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = store_s;
      default:                illegal_s = 1'b1;
    endcase

    // funct3[1:0] encodes size for every legal code (00 byte, 01 half, 10 word).
    case (funct3_i[1:0])
      2'b01:   misaligned_s = addr_i[0];
      2'b10:   misaligned_s = (addr_i[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase

    if (store_s) begin
      case (funct3_i)
        3'b000: begin
          be_s    = 4'b0001 << addr_i[1:0];
          wdata_s = {4{wdata_i[7:0]}};
        end
        3'b001: begin
          be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{wdata_i[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = wdata_i;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = wdata_i;
    end
  end

  assign fail_s    = illegal_s | misaligned_s;
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Next-state selection and the combinational pipeline stall.
  always_comb begin
    state_next_s = state_r;
    stall_o      = 1'b0;
    case (state_r)
      IDLE: begin
        stall_o = access_s;
        if (access_s) begin
          state_next_s = fail_s ? DONE : BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        // Ack on the final counted cycle still completes the access.
        if (dmem_ack_i || timeout_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latching, timeout counter and result/error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r         <= '0;
      funct3_r      <= 3'd0;
      offset_r      <= 2'd0;
      rdata_o       <= 32'd0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
      err_cause_o   <= 2'b00;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 32'd0;
      dmem_be_o     <= 4'd0;
      dmem_wdata_o  <= 32'd0;
    end else begin
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (access_s && fail_s) begin
            err_o       <= 1'b1;
            err_cause_o <= illegal_s ? 2'b11 : 2'b01;
            rdata_o     <= 32'd0;
          end else if (access_s) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= store_s;
            dmem_addr_o  <= {addr_i[31:2], 2'b00};
            dmem_be_o    <= be_s;
            dmem_wdata_o <= wdata_s;
            funct3_r     <= funct3_i;
            offset_r     <= addr_i[1:0];
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (dmem_ack_i) begin
            dmem_req_o    <= 1'b0;
            err_cause_o   <= 2'b00;
            rdata_valid_o <= ~dmem_we_o;
            rdata_o       <= dmem_we_o ? 32'd0
                                       : extend_load(funct3_r, offset_r, dmem_rdata_i);
          end else if (timeout_s) begin
            dmem_req_o  <= 1'b0;
            err_o       <= 1'b1;
            err_cause_o <= 2'b10;
            rdata_o     <= 32'd0;
          end
        end
        DONE:    cnt_r <= '0;
        default: cnt_r <= '0;
      endcase
    end
  end

endmodule
